// File: rtl/button_event.sv
// Button event decoder: press/release edges, short vs. long press, auto-repeat
// while held, and a wrapping press counter. All outputs are registered.
module button_event #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_state,
    input  logic             clr_count,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             short_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic             held,
    output logic [7:0]       press_count
);

    localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sw_prev;
    logic             press_ev, rel_ev;
    logic             press_nx, rel_nx, short_nx, long_nx, repeat_nx;

    assign press_ev = sw_state & ~sw_prev;
    assign rel_ev   = ~sw_state & sw_prev;

    // Release is tested before the threshold so it wins on a coincident edge.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        press_nx  = 1'b0;
        rel_nx    = 1'b0;
        short_nx  = 1'b0;
        long_nx   = 1'b0;
        repeat_nx = 1'b0;
        case (state)
            IDLE: begin
                if (press_ev) begin
                    press_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = PRESSED;
                end
            end
            PRESSED: begin
                if (rel_ev) begin
                    rel_nx   = 1'b1;
                    short_nx = 1'b1;
                    state_nx = IDLE;
                end else if (sw_state) begin
                    if (cnt == LONG_MAX) begin
                        long_nx  = 1'b1;
                        cnt_nx   = '0;
                        state_nx = REPEAT;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            REPEAT: begin
                if (rel_ev) begin
                    rel_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (sw_state) begin
                    if (cnt == REPEAT_MAX) begin
                        repeat_nx = 1'b1;
                        cnt_nx    = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // sw_prev tracks the input even in reset so a button held through reset
    // does not register as a fresh press afterwards.
    always_ff @(posedge clk) begin
        sw_prev <= sw_state;
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            press_pulse   <= press_nx;
            release_pulse <= rel_nx;
            short_pulse   <= short_nx;
            long_pulse    <= long_nx;
            repeat_pulse  <= repeat_nx;
            held          <= (state_nx != IDLE);
            if (clr_count)
                press_count <= 8'd0;
            else if (press_nx)
                press_count <= press_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: directed scenarios plus random button activity,
// compared every cycle against a timeline model of the press duration.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset, sw_state, clr_count;
    logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
    logic [7:0] press_count;

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .sw_state(sw_state), .clr_count(clr_count),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_pulse(short_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .held(held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: remembers the edge a press began and derives the
    // events from the elapsed hold time.
    int   k = 0;
    int   p_edge = 0;
    bit   active = 0;
    bit   m_prev = 0;
    int   m_count = 0;
    logic [13:0] exp_v, obs_v;

    task automatic step(input logic sw, input logic clr, input logic rst, input string tag);
        bit ep, er, es, el, erp;
        int d;
        sw_state  = sw;
        clr_count = clr;
        reset     = rst;
        @(posedge clk);
        k++;
        {ep, er, es, el, erp} = '0;
        if (rst) begin
            active  = 0;
            m_count = 0;
        end else begin
            if (!active && sw && !m_prev) begin
                ep = 1; active = 1; p_edge = k;
            end else if (active && !sw && m_prev) begin
                er = 1; es = ((k - p_edge) <= L); active = 0;
            end else if (active && sw) begin
                d   = k - p_edge;
                el  = (d == L);
                erp = (d > L) && ((d - L) % R == 0);
            end
            if (clr) m_count = 0;
            else if (ep) m_count = (m_count + 1) % 256;
        end
        m_prev = sw;
        exp_v = {ep, er, es, el, erp, active, 8'(m_count)};
        #1;
        obs_v = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held, press_count};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s edge %0d: observed {press,rel,short,long,rep,held,count}=%b required %b",
                   tag, k, obs_v, exp_v);
        end
    endtask

    task automatic hold(input logic sw, input int n, input string tag);
        for (int i = 0; i < n; i++) step(sw, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1; sw_state = 1'b0; clr_count = 1'b0;
        step(0, 0, 1, "reset");
        step(0, 0, 1, "reset");
        hold(0, 3, "idle");

        // long press with two repeats, no short
        hold(1, 18, "long_hold");
        hold(0, 3, "long_release");

        // short press
        hold(1, 5, "short_hold");
        hold(0, 3, "short_release");

        // release exactly on the long threshold edge
        hold(1, 8, "thresh_hold");
        hold(0, 3, "thresh_release");

        // counter wrap
        for (int i = 0; i < 256; i++) begin
            step(1, 0, 0, "wrap");
            step(0, 0, 0, "wrap");
        end
        // clear coincident with press
        step(1, 1, 0, "clr_press");
        hold(0, 2, "clr_release");

        // held through reset
        step(1, 0, 1, "rst_held");
        step(1, 0, 1, "rst_held");
        hold(1, 20, "post_rst_held");
        hold(0, 2, "post_rst_release");
        hold(1, 2, "post_rst_press");
        hold(0, 2, "post_rst_release2");

        // reset mid-press
        hold(1, 5, "mid_press");
        step(1, 0, 1, "mid_reset");
        step(0, 0, 0, "mid_after");
        hold(0, 3, "mid_idle");

        // random activity
        for (int seg = 0; seg < 150; seg++) begin
            logic lvl;
            int   n;
            lvl = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 25);
            for (int i = 0; i < n; i++)
                step(lvl, ($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
